bsg_dram_traffic_tracker: RTL and testbench
===========================================

# bsg_dram_traffic_tracker

Multi-channel request router and completion tracker between a single trace-replay request stream and an N-channel DRAM model (e.g. dramsim3 HBM2). Steers each request to the channel named in the request, limits outstanding requests per channel with a credit counter, counts per-channel read and write completions, and measures elapsed cycles. Asserts `done_o` once the trace is exhausted and every channel has drained. Sits in bandwidth benches, replacing hand-wired channel-0-only hookups and ad-hoc sent/received counters.

## Interface
- `num_channels_p`, default 8: number of DRAM channels; must be ≥ 1.
- `channel_addr_width_p`, default 29: width of the per-channel address.
- `max_outstanding_p`, default 64: per-channel credit limit; must be ≥ 1.
- `counter_width_p`, default 32: width of the statistics counters.
- `lg_ch_lp`: derived, `max(1, $clog2(num_channels_p))`.
- `lg_out_lp`: derived, `$clog2(max_outstanding_p+1)`.

Ports:
- `clk_i`  in  1  clock; all state updates on posedge.
- `reset_i`  in  1  reset, synchronous, active-high.
- `v_i`  in  1  trace request valid.
- `ch_id_i`  in  `lg_ch_lp`  target channel.
- `write_not_read_i`  in  1  request type.
- `ch_addr_i`  in  `channel_addr_width_p`  channel address.
- `yumi_o`  out  1  request accepted this cycle.
- `trace_done_i`  in  1  level; no further `v_i` will arrive.
- `v_o`  out  `num_channels_p`  per-channel request valid.
- `write_not_read_o`  out  `num_channels_p`  per-channel request type.
- `ch_addr_o`  out  `num_channels_p` × `channel_addr_width_p`  per-channel address (broadcast).
- `yumi_i`  in  `num_channels_p`  per-channel accept from the DRAM model.
- `data_v_i`  in  `num_channels_p`  read completion.
- `write_done_i`  in  `num_channels_p`  write completion.
- `done_o`  out  1  trace finished and fully drained.
- `error_o`  out  1  sticky protocol error.
- `read_count_o`  out  `num_channels_p` × `counter_width_p`  read completions per channel.
- `write_count_o`  out  `num_channels_p` × `counter_width_p`  write completions per channel.
- `cycle_count_o`  out  `counter_width_p`  cycles spent in RUN and DRAIN.

## Operation
- Routing is combinational:
  - `v_o[c] = v_i & (ch_id_i == c) & (out_r[c] < max_outstanding_p) & (state != DONE)`.
  - `write_not_read_o[c]` and `ch_addr_o[c]` are broadcast from the inputs.
  - `yumi_o = |(v_o & yumi_i)`.
- `ch_id_i ≥ num_channels_p` with `v_i` high: the request is never accepted and `error_o` is set.
- Credit update: `out_r[c] += issue[c] − data_v_i[c] − write_done_i[c]`.
  - Issue and completions in the same cycle net out.
  - Two completions in one cycle decrement by 2.
- A completion that would underflow `out_r[c]`: `error_o` is set and `out_r[c]` clamps at 0.
- `read_count_o[c]` increments on `data_v_i[c]`; `write_count_o[c]` increments on `write_done_i[c]`. Both wrap modulo 2^`counter_width_p`.
- `cycle_count_o` saturates at all-ones.
- FSM states, encoded in `state_r`:
  - IDLE → RUN on the first `v_i`.
  - IDLE → DRAIN when `trace_done_i` is high with no prior request (empty trace).
  - RUN → DRAIN when `trace_done_i` is high and no request is accepted that cycle.
  - DRAIN → DONE when all `out_r` are 0 and no completion is in flight that cycle.
  - DONE is absorbing until reset.
- `cycle_count_o` increments in every cycle spent in RUN or DRAIN.
- `v_i` high in DRAIN or DONE sets `error_o`; the request is not issued.

## Timing
- Reset values: all counters 0, `out_r` 0, state IDLE, `done_o` 0, `error_o` 0.
- Outputs driven combinationally from inputs: `v_o`, `write_not_read_o`, `ch_addr_o`, `yumi_o`.
- Request path latency is zero cycles: `yumi_o` is asserted in the same cycle as `yumi_i`.
- Credit is visible the cycle after an update. A channel at its limit that receives a completion in cycle t can accept a new request in cycle t+1.
- `done_o` is registered: it rises one cycle after the last completion lowers all `out_r` to 0.
- `read_count_o`, `write_count_o` and `cycle_count_o` reflect events up to the previous cycle.
- Reset asserted mid-run clears all state in the next cycle, including credits owed by the DRAM model; the bench must reset the model together with this block.

## Configuration
- `BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN` defined:
  - Adds output `lat_accum_o`, `num_channels_p` × `counter_width_p`.
  - In RUN and DRAIN, `lat_accum_o[c] += out_r[c]` every cycle, saturating.
  - Average latency is computed by Little's law: `lat_accum / (reads + writes)`.
- Macro undefined: the port and its accumulator logic are absent.

## Structure
- Shared package `bsg_dram_traffic_tracker_pkg`:
  - State enum `{IDLE, RUN, DRAIN, DONE}`.
  - Packed request struct `{write_not_read, ch_addr}`, parameterised by width through the including module.
- One sub-module, `bsg_dram_traffic_tracker_channel`, instantiated per channel. It contains:
  - the credit counter,
  - the underflow check,
  - the read and write counters,
  - the latency accumulator, when the macro is defined.

## Test plan
- Reset mid-run: assert reset with 5 requests outstanding → all outputs return to reset values; after reset and a restarted model, 1 new request completes normally.
- 4 channels, `max_outstanding_p` = 2, 3 reads to channel 1 with completions withheld → 2 `yumi_o` pulses, then `v_o[1]` stays low until the first `data_v_i[1]`; the third read is accepted the next cycle.
- 8 writes round-robin over channels 0–7 followed by `trace_done_i` → each `write_count_o[c]` = 1, `done_o` rises 1 cycle after the last `write_done_i`, and `cycle_count_o` freezes.
- Same-cycle issue, `data_v_i` and `write_done_i` on one channel with `out_r` = 2 → `out_r` = 1 next cycle.
- `data_v_i[3]` while `out_r[3]` = 0 → `error_o` = 1 and stays 1; `out_r[3]` remains 0.
- Empty trace (`trace_done_i` high right after reset, no `v_i`) → `done_o` = 1 within 2 cycles; `cycle_count_o` ≤ 1.

Source files
------------

// File: rtl/bsg_dram_traffic_tracker_pkg.sv
// Shared definitions for the DRAM traffic tracker.
//   - state_e : tracker phase (IDLE, RUN, DRAIN, DONE)
//   - calc_lg_ch : channel-id width, never narrower than one bit
//   - BSG_DRAM_TRAFFIC_TRACKER_REQ_S(addr_w) : packed request struct
//     {write_not_read, ch_addr}. The address width is only known inside
//     the including module, so the struct body is supplied as a macro
//     that the module expands with its own parameter.
package bsg_dram_traffic_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    function automatic int calc_lg_ch(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`define BSG_DRAM_TRAFFIC_TRACKER_REQ_S(addr_w) \
    struct packed { logic write_not_read; logic [(addr_w)-1:0] ch_addr; }

// File: rtl/bsg_dram_traffic_tracker_channel.sv
// Per-channel bookkeeping for the DRAM traffic tracker.
// Optional feature macro: BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN (adds the
// Little's-law latency accumulator and its count_en_i / lat_accum_o ports).
// Ports:
//   clk_i, reset_i  : clock, synchronous active-high reset
//   issue_i         : a request was handed to this channel this cycle
//   data_v_i        : read completion this cycle
//   write_done_i    : write completion this cycle
//   credit_ok_o     : channel is below its outstanding limit
//   idle_o          : nothing outstanding
//   underflow_o     : completions this cycle exceed what is outstanding
//   read_count_o    : read completions seen (wraps)
//   write_count_o   : write completions seen (wraps)
//   count_en_i      : (macro) tracker is in RUN or DRAIN
//   lat_accum_o     : (macro) saturating sum of outstanding count per cycle
module bsg_dram_traffic_tracker_channel #(
    parameter int max_outstanding_p = 64,
    parameter int counter_width_p   = 32,
    parameter int lg_out_lp         = $clog2(max_outstanding_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       issue_i,
    input  logic                       data_v_i,
    input  logic                       write_done_i,
    output logic                       credit_ok_o,
    output logic                       idle_o,
    output logic                       underflow_o,
    output logic [counter_width_p-1:0] read_count_o,
    output logic [counter_width_p-1:0] write_count_o
`ifdef BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN
    ,
    input  logic                       count_en_i,
    output logic [counter_width_p-1:0] lat_accum_o
`endif
);

    localparam int sum_w_lp = lg_out_lp + 1;

    logic [lg_out_lp-1:0]       out_q, out_d;
    logic [sum_w_lp-1:0]        avail;
    logic [1:0]                 ret;
    logic [counter_width_p-1:0] read_q, read_d, write_q, write_d;

    // Issue and completions net out in the same cycle; underflow is judged
    // on the net result and the counter clamps at zero.
    assign avail       = {1'b0, out_q} + sum_w_lp'(issue_i);
    assign ret         = {1'b0, data_v_i} + {1'b0, write_done_i};
    assign underflow_o = avail < sum_w_lp'(ret);
    assign out_d       = underflow_o ? '0 : lg_out_lp'(avail - sum_w_lp'(ret));

    assign credit_ok_o = out_q < lg_out_lp'(max_outstanding_p);
    assign idle_o      = (out_q == '0);

    assign read_d  = read_q + counter_width_p'(data_v_i);
    assign write_d = write_q + counter_width_p'(write_done_i);

    assign read_count_o  = read_q;
    assign write_count_o = write_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_q   <= '0;
            read_q  <= '0;
            write_q <= '0;
        end else begin
            out_q   <= out_d;
            read_q  <= read_d;
            write_q <= write_d;
        end
    end

`ifdef BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN
    logic [counter_width_p-1:0] lat_q, lat_d;
    logic [counter_width_p:0]   lat_sum;

    assign lat_sum = {1'b0, lat_q} + (counter_width_p + 1)'(out_q);

    always_comb begin
        lat_d = lat_q;
        if (count_en_i) begin
            lat_d = lat_sum[counter_width_p] ? '1 : lat_sum[counter_width_p-1:0];
        end
    end

    assign lat_accum_o = lat_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end
`endif

endmodule

// File: rtl/bsg_dram_traffic_tracker.sv
// Routes a single trace-replay request stream onto N DRAM channels, limits
// outstanding requests per channel, counts completions and elapsed cycles,
// and raises done_o once the trace has ended and every channel has drained.
// Optional feature macro: BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN (adds
// lat_accum_o, per-channel saturating sum of outstanding requests).
// Ports:
//   clk_i, reset_i          : clock, synchronous active-high reset
//   v_i, ch_id_i, write_not_read_i, ch_addr_i, yumi_o : trace request side
//   trace_done_i            : level, trace has no more requests
//   v_o, write_not_read_o, ch_addr_o, yumi_i : per-channel request side
//   data_v_i, write_done_i  : per-channel read / write completions
//   done_o                  : trace finished and drained (registered)
//   error_o                 : sticky protocol error
//   read_count_o, write_count_o, cycle_count_o : statistics
module bsg_dram_traffic_tracker
    import bsg_dram_traffic_tracker_pkg::*;
#(
    parameter int num_channels_p       = 8,
    parameter int channel_addr_width_p = 29,
    parameter int max_outstanding_p    = 64,
    parameter int counter_width_p      = 32,
    parameter int lg_ch_lp             = calc_lg_ch(num_channels_p),
    parameter int lg_out_lp            = $clog2(max_outstanding_p + 1)
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_i,
    input  logic                                                 v_i,
    input  logic [lg_ch_lp-1:0]                                  ch_id_i,
    input  logic                                                 write_not_read_i,
    input  logic [channel_addr_width_p-1:0]                      ch_addr_i,
    output logic                                                 yumi_o,
    input  logic                                                 trace_done_i,
    output logic [num_channels_p-1:0]                            v_o,
    output logic [num_channels_p-1:0]                            write_not_read_o,
    output logic [num_channels_p-1:0][channel_addr_width_p-1:0]  ch_addr_o,
    input  logic [num_channels_p-1:0]                            yumi_i,
    input  logic [num_channels_p-1:0]                            data_v_i,
    input  logic [num_channels_p-1:0]                            write_done_i,
    output logic                                                 done_o,
    output logic                                                 error_o,
    output logic [num_channels_p-1:0][counter_width_p-1:0]       read_count_o,
    output logic [num_channels_p-1:0][counter_width_p-1:0]       write_count_o,
    output logic [counter_width_p-1:0]                           cycle_count_o
`ifdef BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN
    ,
    output logic [num_channels_p-1:0][counter_width_p-1:0]       lat_accum_o
`endif
);

    typedef `BSG_DRAM_TRAFFIC_TRACKER_REQ_S(channel_addr_width_p) req_s;

    state_e                     state_q, state_d;
    logic                       error_q, error_d;
    logic [counter_width_p-1:0] cycle_q, cycle_d;

    req_s                       req;
    logic                       accepting;
    logic                       counting;
    logic                       bad_ch;
    logic [num_channels_p-1:0]  credit_ok;
    logic [num_channels_p-1:0]  ch_idle;
    logic [num_channels_p-1:0]  underflow;
    logic [num_channels_p-1:0]  issue;

    assign req = '{write_not_read: write_not_read_i, ch_addr: ch_addr_i};

    // Requests are only steered while the trace is live; a request seen in
    // DRAIN or DONE is a protocol error and is never handed to a channel.
    assign accepting = (state_q == IDLE) || (state_q == RUN);
    assign counting  = (state_q == RUN) || (state_q == DRAIN);

    // An out-of-range channel id is only representable when the channel
    // count is not a power of two.
    if ((1 << lg_ch_lp) > num_channels_p) begin : g_bad_ch
        assign bad_ch = v_i && (32'(ch_id_i) >= num_channels_p);
    end else begin : g_no_bad_ch
        assign bad_ch = 1'b0;
    end

    for (genvar gi = 0; gi < num_channels_p; gi++) begin : g_ch
        assign v_o[gi] = v_i && (ch_id_i == lg_ch_lp'(gi)) && credit_ok[gi] && accepting;
        assign write_not_read_o[gi] = req.write_not_read;
        assign ch_addr_o[gi]        = req.ch_addr;
        assign issue[gi]            = v_o[gi] && yumi_i[gi];

        bsg_dram_traffic_tracker_channel #(
            .max_outstanding_p (max_outstanding_p),
            .counter_width_p   (counter_width_p),
            .lg_out_lp         (lg_out_lp)
        ) u_channel (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .issue_i       (issue[gi]),
            .data_v_i      (data_v_i[gi]),
            .write_done_i  (write_done_i[gi]),
            .credit_ok_o   (credit_ok[gi]),
            .idle_o        (ch_idle[gi]),
            .underflow_o   (underflow[gi]),
            .read_count_o  (read_count_o[gi]),
            .write_count_o (write_count_o[gi])
`ifdef BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN
            ,
            .count_en_i    (counting),
            .lat_accum_o   (lat_accum_o[gi])
`endif
        );
    end

    assign yumi_o = |issue;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (v_i) begin
                    state_d = RUN;
                end else if (trace_done_i) begin
                    state_d = DRAIN;
                end
            end
            RUN: begin
                if (trace_done_i && !yumi_o) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((&ch_idle) && !(|data_v_i) && !(|write_done_i)) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    assign error_d = error_q || bad_ch || (v_i && !accepting) || (|underflow);
    assign cycle_d = (counting && (cycle_q != '1)) ? cycle_q + counter_width_p'(1) : cycle_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            error_q <= 1'b0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            cycle_q <= cycle_d;
        end
    end

    assign done_o        = (state_q == DONE);
    assign error_o       = error_q;
    assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_bsg_dram_traffic_tracker.sv
module tb_bsg_dram_traffic_tracker;

    localparam int NCH = 8;
    localparam int AW  = 12;
    localparam int MAX = 3;
    localparam int CW  = 16;

    logic                     clk = 1'b0;
    logic                     reset_i;
    logic                     v_i;
    logic [2:0]               ch_id_i;
    logic                     write_not_read_i;
    logic [AW-1:0]            ch_addr_i;
    logic                     yumi_o;
    logic                     trace_done_i;
    logic [NCH-1:0]           v_o;
    logic [NCH-1:0]           write_not_read_o;
    logic [NCH-1:0][AW-1:0]   ch_addr_o;
    logic [NCH-1:0]           yumi_i;
    logic [NCH-1:0]           data_v_i;
    logic [NCH-1:0]           write_done_i;
    logic                     done_o;
    logic                     error_o;
    logic [NCH-1:0][CW-1:0]   read_count_o;
    logic [NCH-1:0][CW-1:0]   write_count_o;
    logic [CW-1:0]            cycle_count_o;
`ifdef BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN
    logic [NCH-1:0][CW-1:0]   lat_accum_o;
`endif

    always #5 clk = ~clk;

    bsg_dram_traffic_tracker #(
        .num_channels_p       (NCH),
        .channel_addr_width_p (AW),
        .max_outstanding_p    (MAX),
        .counter_width_p      (CW)
    ) u_dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .v_i              (v_i),
        .ch_id_i          (ch_id_i),
        .write_not_read_i (write_not_read_i),
        .ch_addr_i        (ch_addr_i),
        .yumi_o           (yumi_o),
        .trace_done_i     (trace_done_i),
        .v_o              (v_o),
        .write_not_read_o (write_not_read_o),
        .ch_addr_o        (ch_addr_o),
        .yumi_i           (yumi_i),
        .data_v_i         (data_v_i),
        .write_done_i     (write_done_i),
        .done_o           (done_o),
        .error_o          (error_o),
        .read_count_o     (read_count_o),
        .write_count_o    (write_count_o),
        .cycle_count_o    (cycle_count_o)
`ifdef BSG_DRAM_TRAFFIC_TRACKER_LATENCY_EN
        ,
        .lat_accum_o      (lat_accum_o)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: outstanding count per channel, completion tallies,
    // and the trace life cycle as plain flags.
    int   m_cred [NCH];
    int   m_rd   [NCH];
    int   m_wr   [NCH];
    int   m_cyc;
    bit   m_err;
    bit   m_started;   // a request has been seen
    bit   m_draining;  // trace has ended
    bit   m_finished;  // drained; nothing more happens until reset
    logic [NCH-1:0] m_issue;

    // DRAM model: requests accepted but not yet completed.
    int pend_rd [NCH];
    int pend_wr [NCH];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < NCH; c++) begin
            m_cred[c] = 0; m_rd[c] = 0; m_wr[c] = 0;
            pend_rd[c] = 0; pend_wr[c] = 0;
        end
        m_cyc = 0; m_err = 0;
        m_started = 0; m_draining = 0; m_finished = 0;
        m_issue = '0;
    endtask

    task automatic do_reset();
        reset_i = 1'b1; v_i = 1'b0; ch_id_i = '0; write_not_read_i = 1'b0;
        ch_addr_i = '0; trace_done_i = 1'b0; yumi_i = '0; data_v_i = '0; write_done_i = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_clear();
        chk("rst_done", done_o, 1'b0);
        chk("rst_error", error_o, 1'b0);
        chk("rst_read_count", read_count_o, '0);
        chk("rst_write_count", write_count_o, '0);
        chk("rst_cycle_count", cycle_count_o, '0);
        chk("rst_v_o", v_o, '0);
        reset_i = 1'b0;
        $display("reset: done=%0d error=%0d cycles=%0d", done_o, error_o, cycle_count_o);
    endtask

    // One clock cycle: drive inputs, check the combinational outputs against
    // the model, advance the model and the clock, check registered outputs.
    task automatic step(input bit v, input int ch, input bit wnr, input logic [NCH-1:0] yi,
                        input logic [NCH-1:0] dv, input logic [NCH-1:0] wd, input bit td,
                        output logic [NCH-1:0] act_v, output bit act_y);
        logic [AW-1:0]          addr;
        logic [NCH-1:0]         exp_v;
        bit                     exp_y, accepting, counting, anyc, allz;
        logic [NCH-1:0][AW-1:0] exp_addr;
        logic [NCH-1:0][CW-1:0] exp_rd, exp_wr;
        int                     n;
        addr = AW'($urandom);
        v_i = v; ch_id_i = 3'(ch); write_not_read_i = wnr; ch_addr_i = addr;
        yumi_i = yi; data_v_i = dv; write_done_i = wd; trace_done_i = td;
        #2;
        accepting = !m_draining && !m_finished;
        counting  = (m_started || m_draining) && !m_finished;
        exp_v = '0;
        for (int c = 0; c < NCH; c++) begin
            if (v && accepting && ch == c && m_cred[c] < MAX) exp_v[c] = 1'b1;
            exp_addr[c] = addr;
        end
        exp_y = |(exp_v & yi);
        chk("v_o", v_o, exp_v);
        chk("yumi_o", yumi_o, exp_y);
        chk("write_not_read_o", write_not_read_o, {NCH{wnr}});
        chk("ch_addr_o", ch_addr_o, exp_addr);
        act_v = v_o;
        act_y = yumi_o;
        m_issue = exp_v & yi;

        anyc = (|dv) || (|wd);
        allz = 1;
        for (int c = 0; c < NCH; c++) if (m_cred[c] != 0) allz = 0;
        if (v && !accepting) m_err = 1;
        if (counting && m_cyc < (1 << CW) - 1) m_cyc++;
        if (!m_started && !m_draining) begin
            if (v) m_started = 1;
            else if (td) m_draining = 1;
        end else if (!m_draining) begin
            if (td && !exp_y) m_draining = 1;
        end else if (!m_finished) begin
            if (allz && !anyc) m_finished = 1;
        end
        for (int c = 0; c < NCH; c++) begin
            n = m_cred[c] + int'(m_issue[c]) - int'(dv[c]) - int'(wd[c]);
            if (n < 0) begin
                m_err = 1;
                n = 0;
            end
            m_cred[c] = n;
            m_rd[c] += int'(dv[c]);
            m_wr[c] += int'(wd[c]);
        end

        @(posedge clk);
        #1;
        for (int c = 0; c < NCH; c++) begin
            exp_rd[c] = CW'(m_rd[c]);
            exp_wr[c] = CW'(m_wr[c]);
        end
        chk("error_o", error_o, m_err);
        chk("done_o", done_o, m_finished);
        chk("read_count_o", read_count_o, exp_rd);
        chk("write_count_o", write_count_o, exp_wr);
        chk("cycle_count_o", cycle_count_o, CW'(m_cyc));
        $display("cycle: v=%0d ch=%0d yumi_i=%h dv=%h wd=%h td=%0d -> v_o=%h yumi_o=%0d err=%0d done=%0d cyc=%0d",
                 v, ch, yi, dv, wd, td, act_v, act_y, error_o, done_o, cycle_count_o);
    endtask

    typedef struct {
        bit             v;
        int             ch;
        bit             wnr;
        logic [NCH-1:0] dv;
        logic [NCH-1:0] wd;
        logic [NCH-1:0] exp_v;
        bit             exp_y;
        bit             exp_err;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [NCH-1:0] av, dv, wd;
        bit             ay, v, wnr;
        int             ch;

        // Channel 1 hits its limit of 3, frees one credit, then nets an
        // issue against two completions; channel 3 then underflows.
        tbl[0]  = '{1, 1, 0, 8'h00, 8'h00, 8'h02, 1, 0};
        tbl[1]  = '{1, 1, 0, 8'h00, 8'h00, 8'h02, 1, 0};
        tbl[2]  = '{1, 1, 0, 8'h00, 8'h00, 8'h02, 1, 0};
        tbl[3]  = '{1, 1, 0, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[4]  = '{1, 1, 0, 8'h02, 8'h00, 8'h00, 0, 0};
        tbl[5]  = '{1, 1, 0, 8'h00, 8'h00, 8'h02, 1, 0};
        tbl[6]  = '{0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 0};
        tbl[7]  = '{1, 1, 1, 8'h02, 8'h02, 8'h02, 1, 0};
        tbl[8]  = '{1, 1, 1, 8'h00, 8'h00, 8'h02, 1, 0};
        tbl[9]  = '{1, 1, 1, 8'h00, 8'h00, 8'h02, 1, 0};
        tbl[10] = '{1, 1, 1, 8'h00, 8'h00, 8'h00, 0, 0};
        tbl[11] = '{0, 0, 0, 8'h02, 8'h02, 8'h00, 0, 0};
        tbl[12] = '{0, 0, 0, 8'h02, 8'h00, 8'h00, 0, 0};
        tbl[13] = '{0, 0, 0, 8'h08, 8'h00, 8'h00, 0, 1};
        tbl[14] = '{1, 3, 0, 8'h00, 8'h00, 8'h08, 1, 1};
        tbl[15] = '{1, 3, 0, 8'h00, 8'h00, 8'h08, 1, 1};
        tbl[16] = '{1, 3, 0, 8'h00, 8'h00, 8'h08, 1, 1};
        tbl[17] = '{1, 3, 0, 8'h00, 8'h00, 8'h00, 0, 1};
        tbl[18] = '{0, 0, 0, 8'h08, 8'h08, 8'h00, 0, 1};
        tbl[19] = '{0, 0, 0, 8'h08, 8'h00, 8'h00, 0, 1};

        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].v, tbl[i].ch, tbl[i].wnr, 8'hFF, tbl[i].dv, tbl[i].wd, 1'b0, av, ay);
            chk($sformatf("tbl%0d_v_o", i), av, tbl[i].exp_v);
            chk($sformatf("tbl%0d_yumi", i), ay, tbl[i].exp_y);
            chk($sformatf("tbl%0d_error", i), error_o, tbl[i].exp_err);
        end

        // Eight writes round-robin, end of trace, one completion per channel.
        do_reset();
        for (int c = 0; c < NCH; c++) step(1, c, 1, 8'hFF, '0, '0, 0, av, ay);
        step(0, 0, 0, '0, '0, '0, 1, av, ay);
        for (int c = 0; c < NCH; c++) step(0, 0, 0, '0, '0, 8'(1 << c), 1, av, ay);
        chk("rr_done_after_last_wd", done_o, 1'b0);
        step(0, 0, 0, '0, '0, '0, 1, av, ay);
        chk("rr_done_next", done_o, 1'b1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, '0, '0, '0, 1, av, ay);
        chk("rr_cycle_frozen", cycle_count_o, CW'(17));
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("rr_write_count%0d", c), write_count_o[c], CW'(1));
            chk($sformatf("rr_read_count%0d", c), read_count_o[c], CW'(0));
        end

        // Empty trace, then a request arriving after DONE.
        do_reset();
        step(0, 0, 0, '0, '0, '0, 1, av, ay);
        step(0, 0, 0, '0, '0, '0, 1, av, ay);
        chk("empty_done", done_o, 1'b1);
        chk("empty_cycles_le1", cycle_count_o <= CW'(1), 1'b1);
        step(1, 0, 0, 8'hFF, '0, '0, 1, av, ay);
        chk("done_req_yumi", ay, 1'b0);
        chk("done_req_error", error_o, 1'b1);

        // Reset with five requests outstanding (channel 0 full).
        do_reset();
        for (int k = 0; k < 5; k++) step(1, (k < 3) ? 0 : 1, 0, 8'hFF, '0, '0, 0, av, ay);
        chk("midrun_ch0_full", v_o[0], 1'b0);
        do_reset();
        step(1, 0, 0, 8'hFF, '0, '0, 0, av, ay);
        chk("midrun_post_reset_accept", ay, 1'b1);
        step(0, 0, 0, '0, 8'h01, '0, 0, av, ay);
        chk("midrun_read_count", read_count_o[0], CW'(1));
        chk("midrun_no_error", error_o, 1'b0);

        // Random traffic against the model, then drain.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            v   = ($urandom_range(0, 99) < 60);
            ch  = $urandom_range(0, NCH - 1);
            wnr = 1'($urandom);
            for (int c = 0; c < NCH; c++) begin
                dv[c] = (pend_rd[c] > 0) && ($urandom_range(0, 2) == 0);
                wd[c] = (pend_wr[c] > 0) && ($urandom_range(0, 2) == 0);
            end
            step(v, ch, wnr, NCH'($urandom), dv, wd, 0, av, ay);
            for (int c = 0; c < NCH; c++) begin
                pend_rd[c] += int'(m_issue[c] && !wnr) - int'(dv[c]);
                pend_wr[c] += int'(m_issue[c] && wnr) - int'(wd[c]);
            end
        end
        for (int k = 0; k < 400 && !m_finished; k++) begin
            for (int c = 0; c < NCH; c++) begin
                dv[c] = (pend_rd[c] > 0) && ($urandom_range(0, 1) == 0);
                wd[c] = (pend_wr[c] > 0) && ($urandom_range(0, 1) == 0);
            end
            step(0, 0, 0, '0, dv, wd, 1, av, ay);
            for (int c = 0; c < NCH; c++) begin
                pend_rd[c] -= int'(dv[c]);
                pend_wr[c] -= int'(wd[c]);
            end
        end
        chk("random_drain_done", done_o, 1'b1);
        chk("random_no_error", error_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
